trigger_delay_meter: RTL and testbench
======================================

Name: trigger_delay_meter

Overview:
- Measures the latency between a start trigger and a returned stop trigger, in clock cycles.
- Complements the trigger delay line: that block places a trigger a programmed number of cycles into the future; this block reads back the actual elapsed cycles (loopback calibration, cable/ADC latency measurement).
- Single-shot: software arms it, it captures one start→stop interval, and it presents the result over a valid/ready handshake.

Parameters:
- WIDTH, 16, width of the cycle counter, the timeout value and the result.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- clear  input  1  synchronous abort. Returns to IDLE from any state.
- arm  input  1  single-cycle pulse; arms a measurement.
- start  input  1  start trigger level, synchronous to clk; rising edge is used.
- stop  input  1  stop trigger level, synchronous to clk; rising edge is used.
- timeout  input  WIDTH  max cycles to wait for stop after start. 0 disables the timeout.
- busy  output  1  high in ARMED or COUNTING.
- result  output  WIDTH  measured cycles (stop edge cycle minus start edge cycle).
- timed_out  output  1  qualifies result. 1 means no stop arrived within timeout, or the counter saturated.
- result_valid  output  1  result/timed_out are valid.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - count, result, timed_out, result_valid and busy all go to 0.
  - start_q and stop_q (edge-detect registers) reset to 1, so a level already high at reset release does not produce an edge.
- Edge detection: start_edge = start & ~start_q; stop_edge = stop & ~stop_q. The _q registers update every cycle in every state.
- All outputs are registered.
- FSM states: IDLE, ARMED, COUNTING, DONE.
- clear has top priority in any state:
  - Next state is IDLE.
  - result_valid, busy and timed_out go to 0.
  - result holds its value.
- IDLE:
  - arm=1 → ARMED, with busy=1 on the next cycle.
  - start and stop edges are ignored.
- ARMED:
  - start_edge with no stop_edge → COUNTING, count<=1.
  - start_edge and stop_edge in the same cycle → DONE, with result=0 and timed_out=0.
  - A stop_edge without a start_edge is ignored.
  - arm is ignored.
- COUNTING, checked in this priority order:
  1. stop_edge → DONE, with result=count and timed_out=0.
  2. Else if timeout!=0 and count==timeout → DONE, with result=timeout and timed_out=1.
  3. Else if count==all-ones → DONE, with result=all-ones and timed_out=1 (saturation).
  4. Else count<=count+1.
- COUNTING edge cases:
  - A stop_edge in the same cycle as the timeout condition counts as a valid stop (result=count, timed_out=0).
  - Further start edges are ignored.
  - timeout is sampled live; a change mid-measurement takes effect at once. If timeout is lowered below count, there is no timeout and the counter runs to saturation.
- DONE:
  - result_valid=1; busy=0.
  - result and timed_out are held stable while result_valid=1 and result_ready=0.
  - result_ready=1 → IDLE, with result_valid=0 next cycle.
  - Edges and arm are ignored. An arm arriving in the same cycle as the ready handshake is dropped.
- Latency:
  - result_valid rises the cycle after the cycle in which stop_edge is detected.
  - For a start rising edge sampled at cycle T0 and a stop rising edge at T1, result = T1−T0.
- Arithmetic: unsigned, WIDTH bits. The counter never wraps.

Test Plan:
1. Reset with start=stop=1 held, release, arm, keep both high for 20 cycles → no edges, state stays ARMED, busy=1, result_valid=0.
2. Arm; start rises at cycle 10; stop rises at cycle 47; result_ready=1 → result_valid the cycle after 47, result=37, timed_out=0, back to IDLE next cycle.
3. timeout=5, arm, start edge with no stop → result=5, timed_out=1, result_valid held with result_ready=0 for 8 cycles (result stable), then ready → IDLE.
4. Arm, start and stop rise in the same cycle → result=0, timed_out=0. Separately: stop edge while ARMED before start → ignored, and a later start/stop pair measured correctly.
5. WIDTH=4, timeout=0, start edge, no stop → saturates: result=15, timed_out=1.
6. clear asserted mid-COUNTING → busy=0 next cycle, no result_valid. Also async rst_n pulse mid-DONE → result_valid=0 immediately, result=0.

Source files
------------

// File: rtl/trigger_delay_meter.sv
// Single-shot start->stop latency meter with timeout and saturation.
// The result is held on a valid/ready handshake until the consumer accepts it.
module trigger_delay_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             arm,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] timeout,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             timed_out,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             timed_out_reg, timed_out_next;
  logic             busy_reg, busy_next;
  logic             valid_reg, valid_next;
  logic             start_q, stop_q;
  logic             start_edge, stop_edge;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      result_reg    <= '0;
      timed_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      // Reset high so a level already asserted at release is not seen as an edge
      start_q       <= 1'b1;
      stop_q        <= 1'b1;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      result_reg    <= result_next;
      timed_out_reg <= timed_out_next;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      start_q       <= start;
      stop_q        <= stop;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    result_next    = result_reg;
    timed_out_next = timed_out_reg;

    case (state_reg)
      IDLE: begin
        if (arm) state_next = ARMED;
      end
      ARMED: begin
        if (start_edge && stop_edge) begin
          state_next     = DONE;
          result_next    = '0;
          timed_out_next = 1'b0;
        end else if (start_edge) begin
          state_next = COUNTING;
          count_next = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      COUNTING: begin
        // A stop coinciding with the timeout still counts as a real stop
        if (stop_edge) begin
          state_next     = DONE;
          result_next    = count_reg;
          timed_out_next = 1'b0;
        end else if ((timeout != '0) && (count_reg == timeout)) begin
          state_next     = DONE;
          result_next    = timeout;
          timed_out_next = 1'b1;
        end else if (count_reg == ALL_ONES) begin
          state_next     = DONE;
          result_next    = ALL_ONES;
          timed_out_next = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (clear) begin
      state_next     = IDLE;
      timed_out_next = 1'b0;
    end

    busy_next  = (state_next == ARMED) || (state_next == COUNTING);
    valid_next = (state_next == DONE);
  end

  assign busy         = busy_reg;
  assign result       = result_reg;
  assign timed_out    = timed_out_reg;
  assign result_valid = valid_reg;

endmodule

// File: tb/tb_trigger_delay_meter.sv
// Randomized and directed checks of trigger_delay_meter against an interval model.
module tb_trigger_delay_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, arm, start, stop, result_ready;
  logic [15:0] timeout;
  logic        busy, timed_out, result_valid;
  logic [15:0] result;
  logic [3:0]  timeout4;
  logic        busy4, timed_out4, result_valid4;
  logic [3:0]  result4;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_delay_meter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .arm(arm), .start(start), .stop(stop),
    .timeout(timeout), .busy(busy), .result(result), .timed_out(timed_out),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  trigger_delay_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .arm(arm), .start(start), .stop(stop),
    .timeout(timeout4), .busy(busy4), .result(result4), .timed_out(timed_out4),
    .result_valid(result_valid4), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: a stop L cycles after start yields L, unless a nonzero timeout
  // below L expires first (result=timeout, timed_out=1).
  function automatic void model(input int len, input int tmo,
                                output int exp_k, output int exp_res, output int exp_to);
    if (tmo != 0 && tmo < len) begin
      exp_k = tmo; exp_res = tmo; exp_to = 1;
    end else begin
      exp_k = len; exp_res = len; exp_to = 0;
    end
  endfunction

  task automatic run_measure(input string name, input int pre, input int len, input int tmo,
                             input int hold, input bit pre_stop, input bit arm_at_ready);
    int exp_k, exp_res, exp_to, k;
    bit seen, stable;
    logic [15:0] r0;
    logic        t0;
    model(len, tmo, exp_k, exp_res, exp_to);
    timeout = 16'(tmo);
    arm = 1'b1; tick(); arm = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_armed: busy=%0d valid=%0d expected busy=1 valid=0", name, busy, result_valid);
    end
    repeat (pre) tick();
    if (pre_stop) begin
      stop = 1'b1; tick(); stop = 1'b0; tick();
    end
    start = 1'b1;
    if (len == 0) stop = 1'b1;
    tick();
    k = 0; seen = 0;
    while (!seen && k < len + 5) begin
      if (result_valid === 1'b1) seen = 1;
      else begin
        k++;
        if (k == len) stop = 1'b1;
        tick();
      end
    end
    if (!seen && result_valid === 1'b1) seen = 1;
    chk({name, "_latency"}, seen ? k : -1, exp_k);
    n_tests++;
    if (result !== 16'(exp_res) || timed_out !== 1'(exp_to) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_result: got result=%0d to=%0d busy=%0d expected result=%0d to=%0d busy=0",
               name, result, timed_out, busy, exp_res, exp_to);
    end
    r0 = result; t0 = timed_out; stable = 1;
    result_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (result !== r0 || timed_out !== t0 || result_valid !== 1'b1) stable = 0;
    end
    chk({name, "_hold"}, int'(stable), 1);
    result_ready = 1'b1;
    if (arm_at_ready) arm = 1'b1;
    tick();
    result_ready = 1'b0; arm = 1'b0;
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: valid=%0d busy=%0d expected 0 0", name, result_valid, busy);
    end
    $display("[TB] %s len=%0d tmo=%0d -> result=%0d timed_out=%0d", name, len, tmo, r0, t0);
    start = 1'b0; stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    start = 1'b1; stop = 1'b1; clear = 1'b0; arm = 1'b0; result_ready = 1'b0;
    timeout = '0; timeout4 = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || result !== 16'd0 || timed_out !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0d result=%0d to=%0d valid=%0d expected all 0",
               busy, result, timed_out, result_valid);
    end
    rst_n = 1'b1; tick();
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (20) tick();
    n_tests++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_levels_no_edge: busy=%0d valid=%0d expected 1 0", busy, result_valid);
    end
    $display("[TB] reset with high trigger levels: busy=%0d valid=%0d", busy, result_valid);
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b0; stop = 1'b0;
    chk("clear_from_armed_busy", int'(busy), 0);
    tick();
  endtask

  task automatic test_basic();
    run_measure("basic_37", 9, 37, 0, 2, 0, 0);
  endtask

  task automatic test_timeout();
    run_measure("timeout_5", 2, 100, 5, 8, 0, 0);
  endtask

  task automatic test_edges();
    run_measure("same_cycle", 1, 0, 0, 1, 0, 0);
    run_measure("stop_before_start", 3, 12, 0, 1, 1, 0);
    run_measure("stop_at_timeout", 1, 7, 7, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_measure("b2b_a", 0, 4, 0, 0, 0, 1);
    run_measure("b2b_b", 0, 6, 20, 0, 0, 0);
  endtask

  task automatic test_saturation();
    int k;
    clear = 1'b1; tick(); clear = 1'b0;
    timeout4 = '0; timeout = '0;
    arm = 1'b1; tick(); arm = 1'b0;
    start = 1'b1; tick();
    k = 0;
    while (result_valid4 !== 1'b1 && k < 30) begin
      k++; tick();
    end
    chk("sat_latency", k, 15);
    n_tests++;
    if (result4 !== 4'd15 || timed_out4 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_result: got result=%0d to=%0d expected 15 1", result4, timed_out4);
    end
    $display("[TB] saturation WIDTH=4: result=%0d timed_out=%0d", result4, timed_out4);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("sat_clear_valid", int'(result_valid4), 0);
    start = 1'b0; tick();
  endtask

  task automatic test_clear_and_async_reset();
    int k;
    timeout = '0;
    arm = 1'b1; tick(); arm = 1'b0;
    start = 1'b1; tick();
    repeat (4) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid_count: busy=%0d valid=%0d to=%0d expected 0 0 0",
               busy, result_valid, timed_out);
    end
    stop = 1'b1;
    repeat (4) tick();
    chk("clear_no_result", int'(result_valid), 0);
    $display("[TB] clear mid-count: busy=%0d valid=%0d", busy, result_valid);
    start = 1'b0; stop = 1'b0; tick();
    arm = 1'b1; tick(); arm = 1'b0;
    start = 1'b1; tick(); tick(); tick();
    stop = 1'b1; tick();
    k = 0;
    while (result_valid !== 1'b1 && k < 5) begin
      k++; tick();
    end
    chk("pre_reset_result", int'(result), 3);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (result_valid !== 1'b0 || result !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0d result=%0d busy=%0d expected 0 0 0",
               result_valid, result, busy);
    end
    $display("[TB] async reset mid-done: valid=%0d result=%0d", result_valid, result);
    tick(); rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int len, tmo, pre, hold;
      len  = int'($urandom_range(0, 40));
      tmo  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      pre  = int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 3));
      run_measure("random", pre, len, tmo, hold, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_edges();
    test_back_to_back();
    test_saturation();
    test_clear_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
